pc_gen_unit: RTL
================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised program-counter generator for the fetch stage; the next generation of the plain PC register.
//  Holds the fetch PC and advances it only on a fetch handshake; stall_i freezes it.
//  Applies trap and branch redirects by fixed priority. A redirect that arrives while stalled is latched, never lost.
//  Optionally predicts return targets with a small return-address stack (RAS).
// PARAMETERS
//  XLEN          32     PC width in bits
//  RESET_VECTOR  32'h0  PC value loaded on reset (XLEN bits)
//  INSTR_BYTES   4      sequential increment
//  RAS_DEPTH     4      RAS entries, power of 2, >=2; used only with PC_RAS_EN
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     reset, asynchronous, active-high
//  stall_i          in   1     hold PC (hazard / backpressure)
//  imem_ready_i     in   1     instruction memory accepts pc_o this cycle
//  trap_i           in   1     trap/exception redirect request
//  trap_target_i    in   XLEN  trap handler address
//  br_redirect_i    in   1     branch/jump resolve redirect
//  br_target_i      in   XLEN  resolved target
//  call_i           in   1     instruction at pc_o is a call (RAS push)
//  ret_i            in   1     instruction at pc_o is a return (RAS pop)
//  pc_o             out  XLEN  current fetch PC
//  pc_valid_o       out  1     pc_o is a valid fetch request
//  pc_plus_o        out  XLEN  pc_o + INSTR_BYTES, modulo 2^XLEN
//  redirect_pend_o  out  1     a latched redirect is waiting for the stall to clear
// BEHAVIOUR
//  Reset (async): pc_o=RESET_VECTOR, pc_valid_o=0, redirect_pend_o=0, RAS empty.
//   pc_plus_o follows pc_o combinationally.
//  FSM, 3 states:
//   BOOT: the first cycle after rst falls. pc_valid_o=0. Goes to RUN unconditionally.
//   RUN: pc_valid_o=1.
//   HOLD: redirect latched during a stall. pc_valid_o=1. redirect_pend_o=1.
//  adv = pc_valid_o & imem_ready_i & ~stall_i.
//  Next-PC priority when stall_i=0, applied at the next edge:
//   trap_i > br_redirect_i > latched redirect > RAS return > (adv ? pc_plus_o : pc_o).
//   A live redirect or a latched redirect loads regardless of imem_ready_i; the in-flight fetch is dropped.
//  stall_i=1: pc_o holds.
//   Any trap_i/br_redirect_i is latched (target + kind), and the FSM goes to HOLD.
//   A trap overwrites a latched branch. A later branch does not overwrite a latched trap.
//   A later branch overwrites a latched branch.
//  HOLD with stall_i=0: pc_o <= latched target (or a live trap_i, which wins). Back to RUN.
//  A redirect target has bits [1:0] forced to 0 before loading.
//  Wrap: PC 0xFFFF_FFFC + 4 -> 0x0000_0000 (XLEN=32). No flag is raised.
//  Latency: one clock from a request (or stall release) to the new pc_o.
//  rst mid-operation: returns to BOOT in the same instant. The pending redirect and RAS are discarded.
// CONFIGURATION
//  PC_RAS_EN defined:
//   call_i & adv pushes pc_plus_o. Circular buffer; when full, the oldest entry is overwritten.
//   ret_i & adv & RAS non-empty pops the top; next pc_o = popped value (priority as above).
//   call_i & ret_i together: the top is replaced by pc_plus_o and next pc_o = old top.
//   ret_i with RAS empty -> sequential.
//   trap_i (live or applied) empties the RAS. br_redirect_i leaves it unchanged.
//  PC_RAS_EN undefined: call_i/ret_i are ignored, no RAS storage is built, and RAS_DEPTH is unused.
// STRUCTURE
//  Package pc_pkg: pc_state_e {BOOT,RUN,HOLD}; redirect_kind_e {RD_NONE,RD_BR,RD_TRAP}.
//   Also the constant INSTR_ALIGN_MASK.
//  Sub-module pc_ras (XLEN, RAS_DEPTH): push/pop/clear; outputs top/empty. Instantiated only under PC_RAS_EN.
//  The top level holds the FSM, the pending-redirect register, and the next-PC mux.
// TESTING
//  1 Reset then release, stall_i=0, imem_ready_i=1:
//    pc_valid_o=0 for 1 cycle, then pc_o 0x0,0x4,0x8 on successive cycles.
//  2 imem_ready_i=0 for 3 cycles at pc_o=0x10 -> pc_o holds at 0x10; advances to 0x14 after ready returns.
//  3 stall_i=1, br_redirect_i with target 0x200, then trap_i with target 0x80; release the stall 2 cycles later:
//    redirect_pend_o=1 during the stall, then pc_o=0x80.
//  4 trap_i and br_redirect_i in the same cycle (0x80 vs 0x200) -> pc_o=0x80.
//    br_target_i=0x203 alone -> pc_o=0x200.
//  5 pc_o=0xFFFF_FFFC with adv -> pc_o=0x0. Assert rst mid-HOLD -> pc_o=RESET_VECTOR, redirect_pend_o=0.
//  6 (PC_RAS_EN) call at 0x100, call at 0x300, ret, ret -> predicted pc_o 0x304 then 0x104.
//    Depth+1 calls then pops -> the oldest entry is lost. A ret with the RAS empty -> sequential.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_TRAP = 2'd2
    } redirect_kind_e;

    // Low PC bits cleared on every redirect target.
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/clear, oldest entry overwritten when full.
module pc_ras #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam logic [PtrW:0] Full = (PtrW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] top_q, top_d;
    logic [PtrW:0]   cnt_q, cnt_d;
    logic            wr_en;
    logic [PtrW-1:0] wr_idx;

    always_comb begin
        top_d  = top_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = top_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (push_i && pop_i) begin
            // Call and return together: replace the top in place.
            wr_en = 1'b1;
        end else if (push_i) begin
            top_d  = top_q + 1'b1;
            wr_idx = top_d;
            wr_en  = 1'b1;
            cnt_d  = (cnt_q == Full) ? cnt_q : cnt_q + 1'b1;
        end else if (pop_i) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o   = mem_q[top_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: handshake advance, prioritised trap/branch redirects latched across stalls.
// Optional return-address stack built when PC_RAS_EN is defined.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned    INSTR_BYTES  = 4,
    parameter int unsigned    RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            imem_ready_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_target_i,
    input  logic            br_redirect_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus_o,
    output logic            redirect_pend_o
);

    localparam logic [XLEN-1:0] AlignKeep = ~XLEN'(INSTR_ALIGN_MASK);

    pc_state_e       state_q, state_d;
    redirect_kind_e  pend_kind_q, pend_kind_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            adv, live;
    logic [XLEN-1:0] live_tgt;
    logic            ras_take;
    logic [XLEN-1:0] ras_top;

    assign pc_o            = pc_q;
    assign pc_plus_o       = pc_q + XLEN'(INSTR_BYTES);
    assign pc_valid_o      = (state_q != BOOT);
    assign redirect_pend_o = (state_q == HOLD);

    assign adv      = pc_valid_o & imem_ready_i & ~stall_i;
    assign live     = trap_i | br_redirect_i;
    assign live_tgt = (trap_i ? trap_target_i : br_target_i) & AlignKeep;

`ifdef PC_RAS_EN
    logic ras_ok, ras_empty, ras_push, ras_clear;

    // The stack only tracks fetches that actually proceed sequentially.
    assign ras_ok    = adv & ~live & (state_q != HOLD);
    assign ras_push  = ras_ok & call_i;
    assign ras_take  = ras_ok & ret_i & ~ras_empty;
    assign ras_clear = trap_i | (~stall_i & (state_q == HOLD) & (pend_kind_q == RD_TRAP));

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_take),
        .clear_i     (ras_clear),
        .push_data_i (pc_plus_o),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras_ports;

    assign unused_ras_ports = call_i ^ ret_i;
    assign ras_take         = 1'b0;
    assign ras_top          = '0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_kind_d = pend_kind_q;
        pend_tgt_d  = pend_tgt_q;
        if (stall_i) begin
            if (trap_i) begin
                pend_kind_d = RD_TRAP;
                pend_tgt_d  = live_tgt;
            end else if (br_redirect_i && (pend_kind_q != RD_TRAP)) begin
                pend_kind_d = RD_BR;
                pend_tgt_d  = live_tgt;
            end
            if (live || (state_q == HOLD)) begin
                state_d = HOLD;
            end else if (state_q == BOOT) begin
                state_d = RUN;
            end
        end else begin
            state_d     = RUN;
            pend_kind_d = RD_NONE;
            if (live) begin
                pc_d = live_tgt;
            end else if (state_q == HOLD) begin
                pc_d = pend_tgt_q;
            end else if (ras_take) begin
                pc_d = ras_top;
            end else if (adv) begin
                pc_d = pc_plus_o;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            pend_kind_q <= RD_NONE;
            pend_tgt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_kind_q <= pend_kind_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

endmodule
